// File: rtl/fifo_controller.sv
// rtl/fifo_controller.sv - packet-level write/read controller for the router fifo_memory
module fifo_controller #(
  parameter int DEPTH     = 3,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = 8,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [UWIDTH-1:0]    in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [UWIDTH-1:0]    out_data,
  output logic                 out_last,
  output logic [PTR_SZ:0]      count,
  output logic                 ovf_err,
  output logic                 mem_write_en,
  output logic [PTR_SZ-1:0]    mem_waddr,
  output logic [PTR_IN_SZ-1:0] mem_waddr_in,
  output logic [UWIDTH-1:0]    mem_wdata,
  output logic                 mem_read_en,
  output logic [PTR_SZ-1:0]    mem_raddr,
  output logic [PTR_IN_SZ-1:0] mem_raddr_in,
  input  logic [UWIDTH-1:0]    mem_rdata
);

  typedef enum logic {W_FILL = 1'b0, W_DROP = 1'b1} wstate_t;

  localparam logic [PTR_SZ:0]      FULL_CNT = (PTR_SZ+1)'(DEPTH);
  localparam logic [PTR_SZ-1:0]    LAST_PTR = PTR_SZ'(DEPTH-1);
  localparam logic [PTR_IN_SZ-1:0] LAST_IDX = PTR_IN_SZ'(WIDTH-1);

  wstate_t               wstate_q, wstate_d;
  logic [PTR_SZ-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_IN_SZ-1:0]  widx_q, widx_d, ridx_q, ridx_d;
  logic [PTR_SZ:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [PTR_IN_SZ-1:0]  len_q [DEPTH];
  logic [PTR_IN_SZ-1:0]  len_d [DEPTH];
  logic                  commit, rd_acc, rel;

  always_comb begin
    wstate_d = wstate_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    widx_d   = widx_q;
    ridx_d   = ridx_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    len_d    = len_q;

    in_ready     = (wstate_q == W_FILL) ? (count_q != FULL_CNT) : 1'b1;
    mem_write_en = ~flush & in_valid & in_ready & (wstate_q == W_FILL);
    mem_waddr    = wptr_q;
    mem_waddr_in = widx_q;
    mem_wdata    = in_data;
    commit       = mem_write_en & (in_last | (widx_q == LAST_IDX));

    out_valid    = (count_q != '0);
    mem_read_en  = out_valid & ~flush;
    mem_raddr    = rptr_q;
    mem_raddr_in = ridx_q;
    out_data     = mem_rdata;
    out_last     = out_valid & (ridx_q == len_q[rptr_q] - 1'b1);
    rd_acc       = mem_read_en & out_ready;
    rel          = rd_acc & out_last;

    if (mem_write_en) widx_d = widx_q + 1'b1;
    if (commit) begin
      len_d[wptr_q] = widx_q + 1'b1;
      widx_d        = '0;
      wptr_d        = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      // Oversize packet: keep the truncated head, swallow the rest up to in_last
      if (!in_last) begin
        wstate_d = W_DROP;
        ovf_d    = 1'b1;
      end
    end
    if (!flush && wstate_q == W_DROP && in_valid && in_last) wstate_d = W_FILL;

    if (rd_acc) begin
      ridx_d = ridx_q + 1'b1;
      if (out_last) begin
        ridx_d = '0;
        rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      end
    end

    case ({commit, rel})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Lengths survive a flush; only pointers and occupancy are cleared
    if (flush) begin
      wstate_d = W_FILL;
      wptr_d   = '0;
      rptr_d   = '0;
      widx_d   = '0;
      ridx_d   = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_FILL;
      wptr_q   <= '0;
      rptr_q   <= '0;
      widx_q   <= '0;
      ridx_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) len_q[i] <= '0;
    end else begin
      wstate_q <= wstate_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      widx_q   <= widx_d;
      ridx_q   <= ridx_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      len_q    <= len_d;
    end
  end

  assign count   = count_q;
  assign ovf_err = ovf_q;

endmodule
